// File: rtl/axi_lite_slave_regs.sv
// AXI4-Lite responder with a bank of NUM_REGS 32-bit registers; independent write/read FSMs.
// Define AXI_SLAVE_WSTRB_EN to honour wstrb byte lanes; otherwise every write updates all 32 bits.
module axi_lite_slave_regs #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic                    aclk,
  input  logic                    areset_n,
  input  logic [ADDR_WIDTH-1:0]   awaddr,
  input  logic                    awvalid,
  output logic                    awready,
  input  logic [DATA_WIDTH-1:0]   wdata,
  input  logic [DATA_WIDTH/8-1:0] wstrb,
  input  logic                    wvalid,
  output logic                    wready,
  output logic [1:0]              bresp,
  output logic                    bvalid,
  input  logic                    bready,
  input  logic [ADDR_WIDTH-1:0]   araddr,
  input  logic                    arvalid,
  output logic                    arready,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic [1:0]              rresp,
  output logic                    rvalid,
  input  logic                    rready
);

  localparam int unsigned STRB_W = DATA_WIDTH / 8;
  localparam int unsigned WIDX_W = ADDR_WIDTH - 2;
  localparam int unsigned IDX_W  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [0:0] W_IDLE = 1'b0;
  localparam logic [0:0] W_RESP = 1'b1;
  localparam logic [0:0] R_IDLE = 1'b0;
  localparam logic [0:0] R_DATA = 1'b1;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [0:0]            w_state_q, w_state_d;
  logic                  aw_lat_q, aw_lat_d, w_lat_q, w_lat_d;
  logic [ADDR_WIDTH-1:0] awaddr_q, awaddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [STRB_W-1:0]     wstrb_q, wstrb_d;
  logic                  awready_q, awready_d, wready_q, wready_d;
  logic                  bvalid_q, bvalid_d;
  logic [1:0]            bresp_q, bresp_d;

  logic [0:0]            r_state_q, r_state_d;
  logic                  arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;

  logic [DATA_WIDTH-1:0] regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regs_d [NUM_REGS];

  logic                  aw_hs, w_hs, ar_hs, aw_ok, ar_ok;
  logic [ADDR_WIDTH-1:0] aw_addr_use;
  logic [DATA_WIDTH-1:0] wdata_use;
  logic [STRB_W-1:0]     wstrb_use;
  logic [WIDX_W-1:0]     aw_idx, ar_idx;
  logic                  unused_addr;

  assign aw_hs       = awvalid && awready_q;
  assign w_hs        = wvalid && wready_q;
  assign ar_hs       = arvalid && arready_q;
  // A latched half takes priority; otherwise the half arriving this cycle is used directly.
  assign aw_addr_use = aw_lat_q ? awaddr_q : awaddr;
  assign wdata_use   = w_lat_q ? wdata_q : wdata;
  assign wstrb_use   = w_lat_q ? wstrb_q : wstrb;
  assign aw_idx      = aw_addr_use[ADDR_WIDTH-1:2];
  assign ar_idx      = araddr[ADDR_WIDTH-1:2];
  assign aw_ok       = aw_idx < WIDX_W'(NUM_REGS);
  assign ar_ok       = ar_idx < WIDX_W'(NUM_REGS);
  assign unused_addr = ^{aw_addr_use[1:0], araddr[1:0]};

`ifndef AXI_SLAVE_WSTRB_EN
  logic unused_strb;
  assign unused_strb = ^wstrb_use;
`endif

  // Write channel: collect AW and W in either order, commit when both are present.
  always_comb begin
    w_state_d = w_state_q;
    aw_lat_d  = aw_lat_q;
    w_lat_d   = w_lat_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    regs_d    = regs_q;
    case (w_state_q)
      W_IDLE: begin
        if ((aw_lat_q || aw_hs) && (w_lat_q || w_hs)) begin
          if (aw_ok) begin
`ifdef AXI_SLAVE_WSTRB_EN
            for (int b = 0; b < int'(STRB_W); b++) begin
              if (wstrb_use[b]) regs_d[aw_idx[IDX_W-1:0]][8*b +: 8] = wdata_use[8*b +: 8];
            end
`else
            regs_d[aw_idx[IDX_W-1:0]] = wdata_use;
`endif
          end
          bresp_d   = aw_ok ? RESP_OKAY : RESP_SLVERR;
          bvalid_d  = 1'b1;
          aw_lat_d  = 1'b0;
          w_lat_d   = 1'b0;
          awready_d = 1'b0;
          wready_d  = 1'b0;
          w_state_d = W_RESP;
        end else begin
          if (aw_hs) begin
            aw_lat_d = 1'b1;
            awaddr_d = awaddr;
          end
          if (w_hs) begin
            w_lat_d = 1'b1;
            wdata_d = wdata;
            wstrb_d = wstrb;
          end
          awready_d = !(aw_lat_q || aw_hs);
          wready_d  = !(w_lat_q || w_hs);
        end
      end
      W_RESP: begin
        if (bready) begin
          bvalid_d  = 1'b0;
          bresp_d   = RESP_OKAY;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  // Read channel: capture register contents at the AR handshake, hold until rready.
  always_comb begin
    r_state_d = r_state_q;
    arready_d = arready_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    case (r_state_q)
      R_IDLE: begin
        arready_d = 1'b1;
        if (ar_hs) begin
          rdata_d   = ar_ok ? regs_q[ar_idx[IDX_W-1:0]] : '0;
          rresp_d   = ar_ok ? RESP_OKAY : RESP_SLVERR;
          rvalid_d  = 1'b1;
          arready_d = 1'b0;
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        if (rready) begin
          rvalid_d  = 1'b0;
          arready_d = 1'b1;
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (!areset_n) begin
      w_state_q <= W_IDLE;
      aw_lat_q  <= 1'b0;
      w_lat_q   <= 1'b0;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      r_state_q <= R_IDLE;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= 2'b00;
      for (int i = 0; i < int'(NUM_REGS); i++) regs_q[i] <= '0;
    end else begin
      w_state_q <= w_state_d;
      aw_lat_q  <= aw_lat_d;
      w_lat_q   <= w_lat_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      r_state_q <= r_state_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      regs_q    <= regs_d;
    end
  end

  assign awready = awready_q;
  assign wready  = wready_q;
  assign bvalid  = bvalid_q;
  assign bresp   = bresp_q;
  assign arready = arready_q;
  assign rvalid  = rvalid_q;
  assign rdata   = rdata_q;
  assign rresp   = rresp_q;

endmodule

// File: tb/tb_axi_lite_slave_regs.sv
// Randomised self-checking bench for axi_lite_slave_regs against an array-based register model.
module tb_axi_lite_slave_regs;

  logic        aclk = 1'b0;
  logic        areset_n;
  logic [31:0] awaddr, wdata, araddr, rdata;
  logic [3:0]  wstrb;
  logic        awvalid, awready, wvalid, wready, bvalid, bready;
  logic        arvalid, arready, rvalid, rready;
  logic [1:0]  bresp, rresp;

  int n_checks = 0;
  int n_pass   = 0;
  logic [31:0] mdl [16];

  always #5 aclk = ~aclk;

  axi_lite_slave_regs #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .NUM_REGS(16)) dut (
    .aclk(aclk), .areset_n(areset_n),
    .awaddr(awaddr), .awvalid(awvalid), .awready(awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(wvalid), .wready(wready),
    .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .araddr(araddr), .arvalid(arvalid), .arready(arready),
    .rdata(rdata), .rresp(rresp), .rvalid(rvalid), .rready(rready)
  );

  function automatic logic [1:0] mdl_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    logic [31:0] idx;
    idx = addr / 4;
    if (idx >= 16) return 2'b10;
`ifdef AXI_SLAVE_WSTRB_EN
    for (int b = 0; b < 4; b++) if (strb[b]) mdl[idx][8*b +: 8] = data[8*b +: 8];
`else
    if (strb !== 4'bxxxx) mdl[idx] = data;
`endif
    return 2'b00;
  endfunction

  function automatic logic [31:0] mdl_rdata(input logic [31:0] addr);
    return (addr / 4 < 16) ? mdl[addr / 4] : 32'h0;
  endfunction

  function automatic logic [1:0] mdl_resp(input logic [31:0] addr);
    return (addr / 4 < 16) ? 2'b00 : 2'b10;
  endfunction

  task automatic mdl_clear();
    for (int i = 0; i < 16; i++) mdl[i] = 32'h0;
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  // Drives one write with independent AW/W start delays; reports bvalid right after the commit edge.
  task automatic do_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly,
                          output logic imm_bv, output logic [1:0] resp, output logic to);
    bit aw_done, w_done, awf, wf;
    int cyc;
    aw_done = 0; w_done = 0; cyc = 0; to = 0; imm_bv = 0; resp = 2'b11;
    while (!(aw_done && w_done)) begin
      if (cyc >= 50) begin to = 1; break; end
      if (!aw_done && cyc >= aw_dly) begin awvalid = 1; awaddr = addr; end
      if (!w_done && cyc >= w_dly) begin wvalid = 1; wdata = data; wstrb = strb; end
      awf = awvalid && awready;
      wf  = wvalid && wready;
      tick();
      cyc++;
      if (awf) begin aw_done = 1; awvalid = 0; end
      if (wf)  begin w_done = 1; wvalid = 0; end
    end
    awvalid = 0; wvalid = 0;
    imm_bv = bvalid; resp = bresp;
    cyc = 0;
    while (!(bvalid && bready) && cyc < 50) begin tick(); cyc++; end
    if (cyc >= 50) to = 1; else tick();
  endtask

  task automatic do_read(input logic [31:0] addr, output logic imm_rv, output logic [31:0] rd,
                         output logic [1:0] rr, output logic to);
    bit fire;
    int cyc;
    cyc = 0; to = 0; fire = 0;
    arvalid = 1; araddr = addr;
    while (!fire && cyc < 50) begin
      fire = arvalid && arready;
      tick();
      cyc++;
    end
    arvalid = 0;
    if (!fire) to = 1;
    imm_rv = rvalid; rd = rdata; rr = rresp;
    cyc = 0;
    while (!(rvalid && rready) && cyc < 50) begin tick(); cyc++; end
    if (cyc >= 50) to = 1; else tick();
  endtask

  task automatic test_reset();
    areset_n = 0;
    repeat (3) tick();
    n_checks++;
    if ({awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata} !== 42'h0)
      $display("FAIL reset_outputs: got %h expected 0", {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata});
    else n_pass++;
    areset_n = 1;
    mdl_clear();
    tick();
    n_checks++;
    if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100)
      $display("FAIL reset_release_readies: got %b expected 11100", {awready, wready, arready, bvalid, rvalid});
    else n_pass++;
  endtask

  task automatic test_basic();
    logic bv, rv, to; logic [1:0] br, rr; logic [31:0] rd;
    do_write(32'h08, 32'hDEADBEEF, 4'hF, 0, 0, bv, br, to);
    void'(mdl_write(32'h08, 32'hDEADBEEF, 4'hF));
    n_checks++;
    if ({to, bv, br} !== 4'b0100) $display("FAIL basic_write: got to=%b bvalid=%b bresp=%b expected 0 1 00", to, bv, br);
    else n_pass++;
    do_read(32'h08, rv, rd, rr, to);
    n_checks++;
    if ({to, rv, rr, rd} !== {1'b0, 1'b1, 2'b00, 32'hDEADBEEF})
      $display("FAIL basic_read: got to=%b rvalid=%b rresp=%b rdata=%h expected 0 1 00 deadbeef", to, rv, rr, rd);
    else n_pass++;
  endtask

  task automatic test_w_first();
    logic rv, to; logic [1:0] rr; logic [31:0] rd; bit fire;
    wvalid = 1; wdata = 32'h12345678; wstrb = 4'hF;
    fire = wready;
    tick();
    wvalid = 0;
    n_checks++;
    if (!fire) $display("FAIL wfirst_w_accept: got wready=0 expected 1");
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({wready, awready, bvalid} !== 3'b010)
        $display("FAIL wfirst_hold_%0d: got wready,awready,bvalid=%b expected 010", i, {wready, awready, bvalid});
      else n_pass++;
      if (i < 2) tick();
    end
    awvalid = 1; awaddr = 32'h04;
    tick();
    awvalid = 0;
    void'(mdl_write(32'h04, 32'h12345678, 4'hF));
    n_checks++;
    if ({bvalid, bresp} !== 3'b100) $display("FAIL wfirst_bresp: got bvalid=%b bresp=%b expected 1 00", bvalid, bresp);
    else n_pass++;
    tick();
    n_checks++;
    if ({awready, wready, bvalid} !== 3'b110)
      $display("FAIL wfirst_ready_back: got %b expected 110", {awready, wready, bvalid});
    else n_pass++;
    do_read(32'h04, rv, rd, rr, to);
    n_checks++;
    if ({to, rv, rr, rd} !== {4'b0100, mdl_rdata(32'h04)})
      $display("FAIL wfirst_readback: got rdata=%h rresp=%b expected %h 00", rd, rr, mdl_rdata(32'h04));
    else n_pass++;
  endtask

  task automatic test_slverr();
    logic bv, rv, to; logic [1:0] br, rr; logic [31:0] rd;
    do_write(32'h40, 32'hCAFEF00D, 4'hF, 1, 0, bv, br, to);
    n_checks++;
    if ({to, bv, br} !== {2'b01, mdl_write(32'h40, 32'hCAFEF00D, 4'hF)})
      $display("FAIL slverr_write: got bvalid=%b bresp=%b expected 1 10", bv, br);
    else n_pass++;
    do_read(32'h40, rv, rd, rr, to);
    n_checks++;
    if ({to, rv, rr, rd} !== {2'b01, 2'b10, 32'h0})
      $display("FAIL slverr_read: got rresp=%b rdata=%h expected 10 00000000", rr, rd);
    else n_pass++;
    for (int i = 0; i < 16; i++) begin
      do_read(32'(i * 4), rv, rd, rr, to);
      n_checks++;
      if ({to, rv, rr, rd} !== {4'b0100, mdl_rdata(32'(i * 4))})
        $display("FAIL slverr_bank_%0d: got %h expected %h", i, rd, mdl_rdata(32'(i * 4)));
      else n_pass++;
    end
  endtask

  // Concurrent write and read with both response readies low for 5 cycles.
  task automatic test_stall();
    logic [31:0] wa, ra, wd; logic [44:0] exp_v;
    wa = 32'($urandom_range(0, 7) * 4);
    ra = 32'($urandom_range(8, 15) * 4);
    wd = $urandom;
    bready = 0; rready = 0;
    awvalid = 1; awaddr = wa; wvalid = 1; wdata = wd; wstrb = 4'hF;
    arvalid = 1; araddr = ra;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    exp_v = {1'b1, mdl_write(wa, wd, 4'hF), 1'b1, 2'b00, mdl_rdata(ra), 3'b000};
    for (int i = 0; i < 5; i++) begin
      n_checks++;
      if ({bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready} !== exp_v)
        $display("FAIL stall_cycle_%0d: got %h expected %h", i,
                 {bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready}, exp_v);
      else n_pass++;
      tick();
    end
    bready = 1; rready = 1;
    tick();
    n_checks++;
    if ({bvalid, rvalid, awready, wready, arready} !== 5'b00111)
      $display("FAIL stall_release: got %b expected 00111", {bvalid, rvalid, awready, wready, arready});
    else n_pass++;
  endtask

  task automatic test_wstrb();
    logic bv, rv, to; logic [1:0] br, rr; logic [31:0] rd, exp_d;
    do_write(32'h0C, 32'hAABBCCDD, 4'hF, 0, 0, bv, br, to);
    void'(mdl_write(32'h0C, 32'hAABBCCDD, 4'hF));
    do_write(32'h0C, 32'h11223344, 4'b0101, 0, 2, bv, br, to);
    void'(mdl_write(32'h0C, 32'h11223344, 4'b0101));
`ifdef AXI_SLAVE_WSTRB_EN
    exp_d = 32'hAA22CC44;
`else
    exp_d = 32'h11223344;
`endif
    do_read(32'h0C, rv, rd, rr, to);
    n_checks++;
    if ({to, rv, rr, rd} !== {4'b0100, exp_d})
      $display("FAIL wstrb_merge: got %h expected %h", rd, exp_d);
    else n_pass++;
  endtask

  task automatic test_collision();
    logic [31:0] a, wd, old;
    a = 32'($urandom_range(0, 15) * 4);
    wd = $urandom;
    old = mdl_rdata(a);
    awvalid = 1; awaddr = a; wvalid = 1; wdata = wd; wstrb = 4'hF;
    arvalid = 1; araddr = a;
    tick();
    awvalid = 0; wvalid = 0; arvalid = 0;
    void'(mdl_write(a, wd, 4'hF));
    n_checks++;
    if ({bvalid, rvalid, rdata} !== {2'b11, old})
      $display("FAIL collision_old_value: got bvalid=%b rvalid=%b rdata=%h expected 1 1 %h", bvalid, rvalid, rdata, old);
    else n_pass++;
    tick();
  endtask

  task automatic test_back_to_back();
    logic bv, rv, to; logic [1:0] br, rr; logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      do_write(32'(i * 4), 32'hB0B0_0000 + 32'(i), 4'hF, 0, 0, bv, br, to);
      void'(mdl_write(32'(i * 4), 32'hB0B0_0000 + 32'(i), 4'hF));
      n_checks++;
      if ({to, bv, awready, wready} !== 4'b0111)
        $display("FAIL b2b_write_%0d: got to,bv,awready,wready=%b expected 0111", i, {to, bv, awready, wready});
      else n_pass++;
    end
    for (int i = 0; i < 3; i++) begin
      do_read(32'(i * 4), rv, rd, rr, to);
      n_checks++;
      if ({to, rv, arready, rd} !== {3'b011, mdl_rdata(32'(i * 4))})
        $display("FAIL b2b_read_%0d: got rdata=%h arready=%b expected %h 1", i, rd, arready, mdl_rdata(32'(i * 4)));
      else n_pass++;
    end
  endtask

  task automatic test_random();
    logic bv, rv, to; logic [1:0] br, rr, eresp; logic [31:0] rd, a, d, ed; logic [3:0] s;
    for (int i = 0; i < 40; i++) begin
      a = 32'($urandom_range(0, 19) * 4 + $urandom_range(0, 3));
      d = $urandom;
      s = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        do_write(a, d, s, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), bv, br, to);
        eresp = mdl_write(a, d, s);
        n_checks++;
        if ({to, bv, br} !== {2'b01, eresp})
          $display("FAIL rand_write_%0d: addr=%h got bvalid=%b bresp=%b expected 1 %b", i, a, bv, br, eresp);
        else n_pass++;
      end else begin
        do_read(a, rv, rd, rr, to);
        ed = mdl_rdata(a);
        eresp = mdl_resp(a);
        n_checks++;
        if ({to, rv, rr, rd} !== {2'b01, eresp, ed})
          $display("FAIL rand_read_%0d: addr=%h got rresp=%b rdata=%h expected %b %h", i, a, rr, rd, eresp, ed);
        else n_pass++;
      end
    end
  endtask

  task automatic test_reset_mid();
    logic rv, to; logic [1:0] rr; logic [31:0] rd;
    bready = 0;
    awvalid = 1; awaddr = 32'h14; wvalid = 1; wdata = 32'h5A5A5A5A; wstrb = 4'hF;
    tick();
    awvalid = 0; wvalid = 0;
    n_checks++;
    if (bvalid !== 1'b1) $display("FAIL rstmid_bvalid_pre: got %b expected 1", bvalid);
    else n_pass++;
    areset_n = 0;
    tick();
    mdl_clear();
    n_checks++;
    if ({awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata} !== 42'h0)
      $display("FAIL rstmid_outputs: got %h expected 0", {awready, wready, arready, bvalid, bresp, rvalid, rresp, rdata});
    else n_pass++;
    areset_n = 1;
    bready = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if ({bvalid, awready, wready} !== 3'b011)
        $display("FAIL rstmid_no_resp_%0d: got bvalid,awready,wready=%b expected 011", i, {bvalid, awready, wready});
      else n_pass++;
      tick();
    end
    do_read(32'h14, rv, rd, rr, to);
    n_checks++;
    if ({to, rv, rr, rd} !== {4'b0100, mdl_rdata(32'h14)})
      $display("FAIL rstmid_cleared: got %h expected %h", rd, mdl_rdata(32'h14));
    else n_pass++;
  endtask

  initial begin
    areset_n = 0;
    awaddr = '0; awvalid = 0; wdata = '0; wstrb = '0; wvalid = 0;
    araddr = '0; arvalid = 0; bready = 1; rready = 1;
    mdl_clear();
    #1;
    test_reset();
    test_basic();
    test_w_first();
    test_slverr();
    test_stall();
    test_wstrb();
    test_collision();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
